// File: rtl/way_fill_pkg.sv
// Shared types and sizing helpers for the way-fill demultiplexer.
package way_fill_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } fill_state_t;

  function automatic int beats(input int line_size, input int beat_width);
    return line_size / beat_width;
  endfunction

  // Beat-count width for the default 32-bit line of 8-bit beats.
  localparam int DEF_BEATS = 4;
  localparam int CNT_W     = $clog2(DEF_BEATS);

endpackage

// File: rtl/way_select_decoder.sv
// Binary way index to one-hot write enable; silent for disabled or out-of-range indices.
module way_select_decoder
  import way_fill_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int IDX_W = 3
) (
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [WAYS-1:0]  o_onehot
);

  // Only indices below WAYS can ever match, so out-of-range requests decode to zero.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < WAYS; i++) begin
      o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/way_fill_demux.sv
// Collects serial fill beats into a cache line and pulses a one-hot way write for one cycle.
// Optional macro WAY_FILL_BACK2BACK_EN lets a new request be accepted during the WRITE cycle.
module way_fill_demux
  import way_fill_pkg::*;
#(
  parameter int lineSize  = 32,
  parameter int ways      = 8,
  parameter int beatWidth = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  input  logic [$clog2(ways)-1:0] reqWay,
  output logic                    reqReady,
  input  logic                    beatValid,
  input  logic [beatWidth-1:0]    beatData,
  output logic                    beatReady,
  output logic [ways-1:0]         wayWrite,
  output logic [lineSize-1:0]     lineOut,
  output logic                    busy
);

  localparam int BEATS    = beats(lineSize, beatWidth);
  localparam int CNT_BITS = $clog2(BEATS);
  localparam int WAY_W    = $clog2(ways);

  fill_state_t         r_state;
  fill_state_t         w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [WAY_W-1:0]    r_way;
  logic [lineSize-1:0] r_line;
  logic                w_req_acc;
  logic                w_beat_acc;
  logic                w_write_en;

  always_comb begin
    w_state_nxt = r_state;
    reqReady    = 1'b0;
    beatReady   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        reqReady = 1'b1;
        busy     = 1'b0;
        if (reqValid) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        beatReady = 1'b1;
        if (beatValid && (r_cnt == CNT_BITS'(BEATS - 1))) w_state_nxt = WRITE;
      end
      WRITE: begin
`ifdef WAY_FILL_BACK2BACK_EN
        reqReady    = 1'b1;
        w_state_nxt = reqValid ? COLLECT : IDLE;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_req_acc  = reqValid && reqReady;
  assign w_beat_acc = beatValid && beatReady;
  assign w_write_en = (r_state == WRITE);

  // Unwritten beat slots keep the previous line's bits until overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_way   <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_acc) begin
        r_way <= reqWay;
        r_cnt <= '0;
      end
      if (w_beat_acc) begin
        r_cnt <= r_cnt + CNT_BITS'(1);
        for (int k = 0; k < BEATS; k++) begin
          if (r_cnt == CNT_BITS'(k)) r_line[k*beatWidth +: beatWidth] <= beatData;
        end
      end
    end
  end

  assign lineOut = r_line;

  way_select_decoder #(
    .WAYS  (ways),
    .IDX_W (WAY_W)
  ) u_way_dec (
    .i_en     (w_write_en),
    .i_idx    (r_way),
    .o_onehot (wayWrite)
  );

endmodule

// File: tb/tb_way_fill_demux.sv
// Bench for way_fill_demux: 8-way and 6-way instances share stimulus; scoreboard checks each WRITE cycle.
module tb_way_fill_demux;

  typedef struct {
    logic [2:0]  way;
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [31:0] line;
    logic [7:0]  ww8;
    logic [5:0]  ww6;
  } vec_t;

`ifdef WAY_FILL_BACK2BACK_EN
  localparam int EXP_SPACING = 5;
`else
  localparam int EXP_SPACING = 6;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic [2:0]  reqWay = 3'd0;
  logic        beatValid = 1'b0;
  logic [7:0]  beatData = 8'h00;

  logic        reqReady, beatReady, busy;
  logic [7:0]  ww8;
  logic [31:0] lineOut;
  logic        reqReady6, beatReady6, busy6;
  logic [5:0]  ww6;
  logic [31:0] lineOut6;

  way_fill_demux #(.lineSize(32), .ways(8), .beatWidth(8)) u_dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqWay(reqWay), .reqReady(reqReady),
    .beatValid(beatValid), .beatData(beatData), .beatReady(beatReady),
    .wayWrite(ww8), .lineOut(lineOut), .busy(busy)
  );

  way_fill_demux #(.lineSize(32), .ways(6), .beatWidth(8)) u_dut6 (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqWay(reqWay), .reqReady(reqReady6),
    .beatValid(beatValid), .beatData(beatData), .beatReady(beatReady6),
    .wayWrite(ww6), .lineOut(lineOut6), .busy(busy6)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   nreq = 0;
  int   nbeat = 0;
  bit   started = 1'b0;
  vec_t sb[$];
  vec_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (reqValid && reqReady) nreq++;
      if (beatValid && beatReady) nbeat++;
    end
  end

  // WRITE is the only busy state that does not accept beats.
  always @(negedge clk) begin
    if (started) begin
      if (busy && !beatReady) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_ww8", 64'(ww8), 64'(mon_e.ww8));
          chk("sb_ww6", 64'(ww6), 64'(mon_e.ww6));
          chk("sb_line8", 64'(lineOut), 64'(mon_e.line));
          chk("sb_line6", 64'(lineOut6), 64'(mon_e.line));
          chk("onehot", 64'($countones(ww8) <= 1), 64'd1);
        end
      end else begin
        chk("ww8_outside_write", 64'(ww8), 64'd0);
        chk("ww6_outside_write", 64'(ww6), 64'd0);
      end
    end
  end

  task automatic do_fill(input vec_t v, output int acc_cyc);
    int n;
    logic [7:0] b[4];
    b[0] = v.b0; b[1] = v.b1; b[2] = v.b2; b[3] = v.b3;
    acc_cyc = -1;
    sb.push_back(v);
    reqValid = 1'b1;
    reqWay   = v.way;
    n = 0;
    while (!reqReady && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!reqReady) begin
      chk("req_timeout", 64'd0, 64'd1);
      reqValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc  = cyc;
    reqValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beatValid = 1'b0;
      repeat (v.gap) begin @(posedge clk); #1; end
      beatValid = 1'b1;
      beatData  = b[k];
      @(posedge clk); #1;
    end
    beatValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int a1, a2, req0, beat0;

    tbl[0] = '{3'd3, 8'h11, 8'h22, 8'h33, 8'h44, 0, 32'h44332211, 8'h08, 6'h08};
    tbl[1] = '{3'd3, 8'h11, 8'h22, 8'h33, 8'h44, 2, 32'h44332211, 8'h08, 6'h08};
    tbl[2] = '{3'd7, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 32'hDDCCBBAA, 8'h80, 6'h00};
    tbl[3] = '{3'd0, 8'h01, 8'h02, 8'h03, 8'h04, 1, 32'h04030201, 8'h01, 6'h01};
    tbl[4] = '{3'd5, 8'hF0, 8'h0F, 8'h5A, 8'hA5, 0, 32'hA55A0FF0, 8'h20, 6'h20};
    tbl[5] = '{3'd6, 8'h12, 8'h34, 8'h56, 8'h78, 3, 32'h78563412, 8'h40, 6'h00};

    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    started = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_reqReady", 64'(reqReady), 64'd1);
    chk("rst_beatReady", 64'(beatReady), 64'd0);
    chk("rst_ww8", 64'(ww8), 64'd0);
    chk("rst_line", 64'(lineOut), 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_fill(tbl[i], a1);
      chk($sformatf("lat_ww8_%0d", i), 64'(ww8), 64'(tbl[i].ww8));
      chk($sformatf("lat_ww6_%0d", i), 64'(ww6), 64'(tbl[i].ww6));
      chk($sformatf("lat_line_%0d", i), 64'(lineOut), 64'(tbl[i].line));
      @(posedge clk); #1;
      chk($sformatf("idle_after_%0d", i), 64'(busy), 64'd0);
      chk($sformatf("ww_clear_%0d", i), 64'(ww8), 64'd0);
    end

    // Reset after two beats of a way-5 fill must discard the line.
    reqValid = 1'b1; reqWay = 3'd5;
    @(posedge clk); #1;
    reqValid = 1'b0; beatValid = 1'b1; beatData = 8'h99;
    @(posedge clk); #1;
    beatData = 8'h88;
    @(posedge clk); #1;
    beatValid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_line", 64'(lineOut), 64'd0);
    chk("mid_rst_ww8", 64'(ww8), 64'd0);
    chk("mid_rst_reqReady", 64'(reqReady), 64'd1);
    v = '{3'd1, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 0, 32'h0D0C0B0A, 8'h02, 6'h02};
    do_fill(v, a1);
    chk("post_rst_ww8", 64'(ww8), 64'h02);
    @(posedge clk); #1;

    // Beats offered in IDLE and requests held during COLLECT are not taken early.
    req0 = nreq; beat0 = nbeat;
    beatValid = 1'b1; beatData = 8'h77;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_beat_held", 64'(nbeat - beat0), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    sb.push_back('{3'd2, 8'h77, 8'h77, 8'h77, 8'h77, 0, 32'h77777777, 8'h04, 6'h04});
    reqValid = 1'b1; reqWay = 3'd2;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    reqValid = 1'b0; beatValid = 1'b0;
    chk("hold_req_cnt", 64'(nreq - req0), 64'd1);
    chk("hold_beat_cnt", 64'(nbeat - beat0), 64'd4);
    chk("hold_ww8", 64'(ww8), 64'h04);
    @(posedge clk); #1;

    // Two fills issued as fast as the handshake allows.
    v = '{3'd2, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 0, 32'hC4C3C2C1, 8'h04, 6'h04};
    do_fill(v, a1);
    v = '{3'd6, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 0, 32'hD4D3D2D1, 8'h40, 6'h00};
    do_fill(v, a2);
    chk("b2b_spacing", 64'(a2 - a1), 64'(EXP_SPACING));
    chk("b2b_ww8", 64'(ww8), 64'h40);
    repeat (2) begin @(posedge clk); #1; end

    chk("total_req", 64'(nreq), 64'd11);
    chk("total_beats", 64'(nbeat), 64'd42);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
